// File: rtl/y_p2s_tx_pkg.sv
// Shared definitions for the y result link (transmit side now, receive side later).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: default result width, FSM state encoding, FIFO level width helper.
package y_p2s_tx_pkg;

  // Default result word width (two's complement, sent unmodified).
  localparam int WIDTH_DEF = 12;

  // Serializer FSM states; encoding is shared with the future receive side.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } st_t;

  // Occupancy counter width: must hold 0..DEPTH inclusive.
  function automatic int lvl_bits(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/y_p2s_tx_if.sv
// Result-word handshake between the datapath (master) and the serializer (slave).
// Latency: n/a (wires only).
// Backpressure: y_ready low means the slave drops any y_valid this cycle.
// Signals: y_in (result word), y_valid (new word this cycle), y_ready (slave can accept).
interface y_p2s_tx_if #(
  parameter int WIDTH = 12
);
  logic [WIDTH-1:0] y_in;
  logic             y_valid;
  logic             y_ready;

  modport master (output y_in, output y_valid, input y_ready);
  modport slave  (input y_in, input y_valid, output y_ready);
endinterface

// File: rtl/y_p2s_tx_fifo.sv
// y_fifo: synchronous FIFO buffering result words ahead of the serializer.
// Latency: a write is visible at the head (rd_data) one edge later; rd_data is the current head.
// Backpressure: writes while full and reads while empty are ignored internally.
// Ports: clk, rst (sync, active-high), wr_en/wr_data, rd_en/rd_data, level (registered), full, empty.
module y_fifo #(
  parameter  int WIDTH = 12,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_wr;
  logic             w_rd;

  assign full    = (r_level == LW'(DEPTH));
  assign empty   = (r_level == '0);
  assign w_wr    = wr_en && !full;
  assign w_rd    = rd_en && !empty;
  assign rd_data = r_mem[r_rd_ptr];
  assign level   = r_level;

  // Storage needs no reset: the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Pointers are exactly AW bits, so DEPTH being a power of 2 gives free wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/y_p2s_tx.sv
// y_p2s_tx: buffers signed result words and sends them MSB-first on one pin with a frame pulse.
// Latency: write at edge t into an empty idle block -> pop at t+1 -> MSB on sout after t+1.
// Backpressure: y_ready = FIFO not full; a y_valid while full is dropped and sets sticky ovf.
// Ports: clk, rst (sync, active-high); y_if (slave: y_in/y_valid/y_ready); ovf_clr;
//        sout/sframe/sactive (registered serial side); level (FIFO occupancy); ovf (sticky drop flag).
module y_p2s_tx
  import y_p2s_tx_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  parameter  int DEPTH = 4,
  parameter  int GAP   = 1,
  localparam int LW    = lvl_bits(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  y_p2s_tx_if.slave      y_if,
  input  logic           ovf_clr,
  output logic           sout,
  output logic           sframe,
  output logic           sactive,
  output logic [LW-1:0]  level,
  output logic           ovf
);

  localparam int         BW     = $clog2(WIDTH);
  localparam logic [3:0] GAP_M1 = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  logic             w_full;
  logic             w_empty;
  logic             w_wr_en;
  logic             w_ovf_set;
  logic             w_pop;
  logic             w_start;
  logic [WIDTH-1:0] w_head;

  st_t              r_state,  w_state_nxt;
  logic [BW-1:0]    r_bit,    w_bit_nxt;
  logic [3:0]       r_gap,    w_gap_nxt;
  logic [WIDTH-1:0] r_sh,     w_sh_nxt;
  logic             r_sout,   w_sout_nxt;
  logic             r_sframe, w_sframe_nxt;
  logic             r_sactive, w_sactive_nxt;
  logic             r_ovf;

  // Acceptance is judged on the pre-edge level, so a pop on the same edge
  // does not make room for a write arriving while full.
  assign w_wr_en     = y_if.y_valid && !w_full;
  assign w_ovf_set   = y_if.y_valid && w_full;
  assign y_if.y_ready = !w_full;

  y_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_wr_en),
    .wr_data (y_if.y_in),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .level   (level),
    .full    (w_full),
    .empty   (w_empty)
  );

  // Next-state and registered-output logic. r_sh is shifted left each bit,
  // so the next bit to send is always r_sh[WIDTH-2].
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_nxt     = r_bit;
    w_gap_nxt     = r_gap;
    w_sh_nxt      = r_sh;
    w_sout_nxt    = 1'b0;
    w_sframe_nxt  = 1'b0;
    w_sactive_nxt = 1'b0;
    w_start       = 1'b0;
    w_pop         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_start = !w_empty;
      end
      ST_SHIFT: begin
        if (r_bit != '0) begin
          w_bit_nxt     = r_bit - 1'b1;
          w_sh_nxt      = {r_sh[WIDTH-2:0], 1'b0};
          w_sout_nxt    = r_sh[WIDTH-2];
          w_sactive_nxt = 1'b1;
        end else if (GAP > 0) begin
          w_state_nxt = ST_GAP;
          w_gap_nxt   = GAP_M1;
        end else begin
          // No gap: chain straight into the next word if one is waiting.
          w_start     = !w_empty;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (r_gap != '0) begin
          w_gap_nxt = r_gap - 1'b1;
        end else begin
          w_start     = !w_empty;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Pop edge: load the word and present its MSB with the frame pulse.
    if (w_start) begin
      w_pop         = 1'b1;
      w_state_nxt   = ST_SHIFT;
      w_sh_nxt      = w_head;
      w_bit_nxt     = BW'(WIDTH - 1);
      w_sout_nxt    = w_head[WIDTH-1];
      w_sframe_nxt  = 1'b1;
      w_sactive_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_bit     <= '0;
      r_gap     <= '0;
      r_sh      <= '0;
      r_sout    <= 1'b0;
      r_sframe  <= 1'b0;
      r_sactive <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit     <= w_bit_nxt;
      r_gap     <= w_gap_nxt;
      r_sh      <= w_sh_nxt;
      r_sout    <= w_sout_nxt;
      r_sframe  <= w_sframe_nxt;
      r_sactive <= w_sactive_nxt;
      // A drop on the same edge as a clear wins, so no overflow goes unseen.
      if (w_ovf_set)    r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign sout    = r_sout;
  assign sframe  = r_sframe;
  assign sactive = r_sactive;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_y_p2s_tx.sv
// Testbench for y_p2s_tx: GAP=1 instance (dut1) with a serial-side scoreboard monitor,
// GAP=0 instance (dut0) for back-to-back streaming.
// Ports of both instances are fully connected; clocks generated here.
module tb_y_p2s_tx;
  import y_p2s_tx_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  y_p2s_tx_if #(.WIDTH(12)) if1 ();
  y_p2s_tx_if #(.WIDTH(12)) if0 ();

  logic       clr1, clr0;
  logic       sout1, sframe1, sactive1, ovf1;
  logic       sout0, sframe0, sactive0, ovf0;
  logic [2:0] level1, level0;

  y_p2s_tx #(.WIDTH(12), .DEPTH(4), .GAP(1)) dut1 (
    .clk(clk), .rst(rst), .y_if(if1), .ovf_clr(clr1),
    .sout(sout1), .sframe(sframe1), .sactive(sactive1), .level(level1), .ovf(ovf1)
  );

  y_p2s_tx #(.WIDTH(12), .DEPTH(4), .GAP(0)) dut0 (
    .clk(clk), .rst(rst), .y_if(if0), .ovf_clr(clr0),
    .sout(sout0), .sframe(sframe0), .sactive(sactive0), .level(level0), .ovf(ovf0)
  );

  int n_checks = 0;
  int n_err    = 0;

  logic [11:0] q1 [$];
  logic [11:0] q0 [$];
  int          frame_cyc [$];
  int          cyc   = 0;
  int          n_sf  = 0;
  int          m_cnt = 0;
  logic [11:0] m_word = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic [11:0] d, input logic acc);
    chk("y_ready1", 32'(if1.y_ready), 32'(acc));
    if1.y_valid = 1'b1;
    if1.y_in    = d;
    if (acc) q1.push_back(d);
    tick();
    if1.y_valid = 1'b0;
  endtask

  task automatic drive0(input logic [11:0] d);
    chk("y_ready0", 32'(if0.y_ready), 32'd1);
    if0.y_valid = 1'b1;
    if0.y_in    = d;
    q0.push_back(d);
    tick();
    if0.y_valid = 1'b0;
  endtask

  // Serial monitor for dut1: rebuilds each word and compares with the scoreboard.
  always @(negedge clk) begin
    cyc++;
    if (sframe1) n_sf++;
    if (rst) begin
      m_cnt = 0;
    end else if (sactive1) begin
      chk("sframe_pos", 32'(sframe1), 32'(m_cnt == 0));
      m_word = {m_word[10:0], sout1};
      m_cnt++;
      if (m_cnt == 12) begin
        chk("word_expected", 32'(q1.size() != 0), 32'd1);
        if (q1.size() != 0) chk("word_data", 32'(m_word), 32'(q1.pop_front()));
        frame_cyc.push_back(cyc);
        m_cnt = 0;
      end
    end else begin
      chk("idle_lines", 32'({sout1, sframe1}), 32'd0);
      m_cnt = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [25:0] fm_obs, fm_exp;
    logic [23:0] bits_obs, bits_exp;
    logic [11:0] e_a, e_b;
    int          n_act, sf_before;
    logic        s_act [26];
    logic        s_fr  [26];
    logic        s_out [26];

    // 1: reset with y_valid held high
    rst = 1'b1; clr1 = 1'b0; clr0 = 1'b0;
    if1.y_valid = 1'b1; if1.y_in = 12'hABC;
    if0.y_valid = 1'b1; if0.y_in = 12'hABC;
    tick(); tick();
    chk("rst_level", 32'(level1), 32'd0);
    chk("rst_serial", 32'({sout1, sframe1, sactive1, ovf1}), 32'd0);
    chk("rst_ready", 32'(if1.y_ready), 32'd1);
    chk("rst_level0", 32'(level0), 32'd0);
    rst = 1'b0; if1.y_valid = 1'b0; if0.y_valid = 1'b0;
    repeat (20) tick();
    chk("rst_nothing_sent", 32'(n_sf), 32'd0);

    // 2: single word 8F3, GAP=1
    drive1(12'h8F3, 1'b1);
    chk("t2_level_after_write", 32'(level1), 32'd1);
    chk("t2_no_frame_yet", 32'(sframe1), 32'd0);
    tick();
    chk("t2_msb", 32'({sframe1, sactive1, sout1}), 32'b111);
    chk("t2_level_after_pop", 32'(level1), 32'd0);
    repeat (11) tick();
    chk("t2_lsb", 32'({sframe1, sactive1, sout1}), 32'b011);
    tick();
    chk("t2_gap", 32'({sactive1, sout1}), 32'd0);
    chk("t2_gap_state", 32'(dut1.r_state), 32'(ST_GAP));
    tick();
    chk("t2_idle_state", 32'(dut1.r_state), 32'(ST_IDLE));

    // 3: burst of 5 consecutive words
    frame_cyc.delete();
    for (int i = 1; i <= 5; i++) drive1(12'(i), 1'b1);
    chk("t3_level_max", 32'(level1), 32'd4);
    chk("t3_ovf", 32'(ovf1), 32'd0);
    repeat (80) tick();
    chk("t3_words_sent", 32'(frame_cyc.size()), 32'd5);
    for (int i = 1; i < frame_cyc.size(); i++)
      chk("t3_spacing", 32'(frame_cyc[i] - frame_cyc[i-1]), 32'd13);
    chk("t3_queue_drained", 32'(q1.size()), 32'd0);

    // 4: overflow while mid-SHIFT
    drive1(12'h100, 1'b1);
    tick();
    chk("t4_shifting", 32'(sactive1), 32'd1);
    drive1(12'h101, 1'b1);
    drive1(12'h102, 1'b1);
    drive1(12'h103, 1'b1);
    drive1(12'h104, 1'b1);
    chk("t4_full_level", 32'(level1), 32'd4);
    drive1(12'h7FF, 1'b0);
    chk("t4_ovf_set", 32'(ovf1), 32'd1);
    chk("t4_level_held", 32'(level1), 32'd4);
    clr1 = 1'b1;
    drive1(12'h7FE, 1'b0);
    chk("t4_set_beats_clr", 32'(ovf1), 32'd1);
    tick();
    clr1 = 1'b0;
    chk("t4_clr", 32'(ovf1), 32'd0);
    repeat (70) tick();
    chk("t4_queue_drained", 32'(q1.size()), 32'd0);

    // 5: GAP=0 streaming on dut0
    drive0(12'hFFF);
    drive0(12'h000);
    for (int k = 0; k < 26; k++) begin
      s_act[k] = sactive0; s_fr[k] = sframe0; s_out[k] = sout0;
      tick();
    end
    n_act = 0;
    while (n_act < 26 && s_act[n_act]) n_act++;
    chk("t5_contiguous", 32'(n_act), 32'd24);
    chk("t5_after_stream", 32'({s_act[24], s_act[25]}), 32'd0);
    fm_obs = '0; fm_exp = '0; fm_exp[0] = 1'b1; fm_exp[12] = 1'b1;
    bits_obs = '0;
    for (int k = 0; k < 26; k++) fm_obs[k] = s_fr[k];
    for (int k = 0; k < 24; k++) bits_obs = {bits_obs[22:0], s_out[k]};
    chk("t5_sframe_pos", 32'(fm_obs), 32'(fm_exp));
    chk("t5_q0_size", 32'(q0.size()), 32'd2);
    e_a = q0.pop_front();
    e_b = q0.pop_front();
    bits_exp = {e_a, e_b};
    chk("t5_bits", 32'(bits_obs), 32'(bits_exp));
    chk("t5_ovf0", 32'(ovf0), 32'd0);

    // 6: reset during bit 5 with two words queued
    drive1(12'hA5A, 1'b1);
    drive1(12'h123, 1'b1);
    drive1(12'h456, 1'b1);
    chk("t6_queued", 32'(level1), 32'd2);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    chk("t6_sout", 32'({sout1, sactive1, sframe1}), 32'd0);
    chk("t6_level", 32'(level1), 32'd0);
    chk("t6_state", 32'(dut1.r_state), 32'(ST_IDLE));
    rst = 1'b0;
    q1.delete();
    sf_before = n_sf;
    repeat (40) tick();
    chk("t6_no_resume", 32'(n_sf - sf_before), 32'd0);

    chk("end_q1_empty", 32'(q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
